// File: rtl/sdhcal_daq_pkg.sv
// Shared types and defaults for the SDHCAL DAQ readout path.
package sdhcal_daq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] DEF_HEADER_WORD = 16'hFFFF;
    localparam logic [3:0] DEF_TRAILER_TAG = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SHIFT,
        FLUSH,
        TRAILER,
        DONE
    } state_t;

    // Partial word of n valid bits (LSB-aligned in v) moved to the MSBs, zero padded.
    function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] v,
                                                     input logic [3:0] n);
        return v << (WORD_W - 32'(n));
    endfunction

endpackage

// File: rtl/asic_readout_collector_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, with rise/fall pulses
// detected on the synchronised (second-stage) value.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            s2_d <= RST_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s2_d;
    assign fall = ~s2 & s2_d;

endmodule

// File: rtl/asic_readout_collector.sv
// Clocks the ASIC digital-RAM serial readout, deserialises DOUT into 16-bit
// words and writes header/data/trailer frames to the USB-side FIFO.
module asic_readout_collector
    import sdhcal_daq_pkg::*;
#(
    parameter int unsigned        CLK_DIV     = 4,
    parameter logic [WORD_W-1:0]  HEADER_WORD = DEF_HEADER_WORD,
    parameter logic [3:0]         TRAILER_TAG = DEF_TRAILER_TAG,
    parameter logic [15:0]        TIMEOUT     = 16'd40000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        StartReadout,
    input  logic        TRANSMITON_B,
    input  logic        DOUT,
    output logic        CK_READ,
    output logic [15:0] FifoData,
    output logic        FifoWrEn,
    input  logic        FifoFull,
    output logic        ReadoutBusy,
    output logic        FrameDone,
    output logic [15:0] WordCount,
    output logic        Overflow,
    output logic        Timeout
);

    localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 1);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    state_t state;
    state_t next_state;

    logic start_q, start_rise, unused_start_fall;
    logic tx_b, tx_rise, unused_tx_fall;
    logic dout_s, unused_dout_rise, unused_dout_fall;

    logic [15:0]       div_cnt;
    logic              ck_read;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shift_in;
    logic [3:0]        bit_cnt;
    logic [15:0]       timeout_cnt;
    logic [15:0]       word_count;
    logic              overflow;
    logic              timeout_flag;
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_wr_en;

    logic              running;
    logic              running_next;
    logic              sample_tick;
    logic              wr_req;
    logic [WORD_W-1:0] wr_data;
    logic              clear_frame;
    logic              shift_en;
    logic              count_word;
    logic              set_timeout;

    sync_edge_det #(.RST_VAL(1'b0)) u_sync_start (
        .Clk(Clk), .reset(reset), .d(StartReadout),
        .q(start_q), .rise(start_rise), .fall(unused_start_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sync_tx (
        .Clk(Clk), .reset(reset), .d(TRANSMITON_B),
        .q(tx_b), .rise(tx_rise), .fall(unused_tx_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sync_dout (
        .Clk(Clk), .reset(reset), .d(DOUT),
        .q(dout_s), .rise(unused_dout_rise), .fall(unused_dout_fall)
    );

    assign running      = (state == ARMED) || (state == SHIFT);
    assign running_next = (next_state == ARMED) || (next_state == SHIFT);
    // Tick is the cycle whose edge drives CK_READ 0->1; DOUT is sampled here.
    assign sample_tick  = running && (div_cnt == DIV_LAST) && !ck_read;
    assign shift_in     = {shift_reg[WORD_W-2:0], dout_s};

    always_comb begin
        next_state  = state;
        wr_req      = 1'b0;
        wr_data     = '0;
        clear_frame = 1'b0;
        shift_en    = 1'b0;
        count_word  = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    clear_frame = 1'b1;
                    wr_req      = 1'b1;
                    wr_data     = HEADER_WORD;
                    next_state  = ARMED;
                end
            end
            ARMED: begin
                if (sample_tick && !tx_b) begin
                    shift_en   = 1'b1;
                    next_state = SHIFT;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = TRAILER;
                end
            end
            SHIFT: begin
                if (tx_rise) begin
                    next_state = FLUSH;
                end else if (sample_tick && !tx_b) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd15) begin
                        wr_req     = 1'b1;
                        wr_data    = shift_in;
                        count_word = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (bit_cnt != 4'd0) begin
                    wr_req     = 1'b1;
                    wr_data    = left_align(shift_reg, bit_cnt);
                    count_word = 1'b1;
                end
                next_state = TRAILER;
            end
            TRAILER: begin
                wr_req     = 1'b1;
                wr_data    = {TRAILER_TAG, word_count[11:0]};
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            ck_read      <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            timeout_cnt  <= '0;
            word_count   <= '0;
            overflow     <= 1'b0;
            timeout_flag <= 1'b0;
            fifo_data    <= '0;
            fifo_wr_en   <= 1'b0;
        end else begin
            state <= next_state;

            // Divider follows next_state so CK_READ drops the same edge the FSM leaves SHIFT/ARMED.
            if (!running_next) begin
                div_cnt <= '0;
                ck_read <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                ck_read <= ~ck_read;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end

            fifo_wr_en <= wr_req && !FifoFull;
            if (wr_req && !FifoFull) begin
                fifo_data <= wr_data;
            end
            overflow     <= (overflow && !clear_frame) || (wr_req && FifoFull);
            timeout_flag <= (timeout_flag && !clear_frame) || set_timeout;

            if (shift_en) begin
                shift_reg <= shift_in;
            end
            if (clear_frame) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (clear_frame) begin
                timeout_cnt <= '0;
            end else if (state == ARMED) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end

            if (clear_frame) begin
                word_count <= '0;
            end else if (count_word && (word_count != '1)) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

    assign CK_READ     = ck_read;
    assign FifoData    = fifo_data;
    assign FifoWrEn    = fifo_wr_en;
    assign ReadoutBusy = (state != IDLE);
    assign FrameDone   = (state == DONE);
    assign WordCount   = word_count;
    assign Overflow    = overflow;
    assign Timeout     = timeout_flag;

endmodule
